// File: rtl/nanorv32_div_seq.sv
// Sequencer between the execute stage and the shared iterative divider.
// Resolves RISC-V divide-by-zero/overflow locally, otherwise issues to the divider and waits.
module nanorv32_div_seq #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_WIDTH      = 7
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        op_valid,
  output logic        op_ready,
  input  logic [1:0]  op_sel,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic        op_kill,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [31:0] res_data,
  output logic        res_err,
  output logic        busy,
  output logic        div_req_valid,
  input  logic        div_req_ready,
  output logic        div_req_signed,
  output logic        div_req_rem,
  output logic [31:0] div_req_a,
  output logic [31:0] div_req_b,
  input  logic        div_resp_valid,
  input  logic [31:0] div_resp_result
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_DONE  = 3'd3,
    S_DRAIN = 3'd4
  } state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_ZERO = CNT_WIDTH'(0);

  state_t                 state_r, state_s;
  logic [CNT_WIDTH-1:0]   cnt_r, cnt_s;
  logic [1:0]             sel_r;
  logic [31:0]            a_r, b_r;
  logic [31:0]            res_data_r, res_data_s;
  logic                   res_err_r, res_err_s;
  logic                   accept_s;

  // Operations whose result is architecturally fixed and never reach the divider.
  function automatic logic is_fast(input logic [1:0] sel, input logic [31:0] a, input logic [31:0] b);
    logic hit;
    if (b == 32'h0000_0000) begin
      hit = 1'b1;
    end else if (!sel[0] && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF)) begin
      hit = 1'b1;
    end else begin
      hit = 1'b0;
    end
    return hit;
  endfunction

  // Result of a fast-path operation: sel[1] selects remainder.
  function automatic logic [31:0] fast_result(input logic [1:0] sel, input logic [31:0] a,
                                              input logic [31:0] b);
    logic [31:0] r;
    if (b == 32'h0000_0000) begin
      r = sel[1] ? a : 32'hFFFF_FFFF;
    end else begin
      r = sel[1] ? 32'h0000_0000 : 32'h8000_0000;
    end
    return r;
  endfunction

  // Next-state, watchdog counter and result register updates.
  always_comb begin
    state_s    = state_r;
    cnt_s      = cnt_r;
    res_data_s = res_data_r;
    res_err_s  = res_err_r;
    accept_s   = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (op_valid && !op_kill) begin
          accept_s = 1'b1;
          if (is_fast(op_sel, op_a, op_b)) begin
            state_s    = S_DONE;
            res_data_s = fast_result(op_sel, op_a, op_b);
            res_err_s  = 1'b0;
          end else begin
            state_s = S_ISSUE;
          end
        end else begin
          state_s = S_IDLE;
        end
      end
      S_ISSUE: begin
        if (op_kill) begin
          // A request the divider already took must still be drained.
          if (div_req_ready) begin
            state_s = S_DRAIN;
            cnt_s   = CNT_ZERO;
          end else begin
            state_s = S_IDLE;
          end
        end else if (div_req_ready) begin
          state_s = S_WAIT;
          cnt_s   = CNT_ZERO;
        end else begin
          state_s = S_ISSUE;
        end
      end
      S_WAIT: begin
        cnt_s = cnt_r + CNT_ONE;
        if (op_kill) begin
          state_s = div_resp_valid ? S_IDLE : S_DRAIN;
        end else if (div_resp_valid) begin
          state_s    = S_DONE;
          res_data_s = div_resp_result;
          res_err_s  = 1'b0;
        end else if (cnt_r == CNT_LAST) begin
          state_s    = S_DONE;
          res_data_s = 32'h0000_0000;
          res_err_s  = 1'b1;
        end else begin
          state_s = S_WAIT;
        end
      end
      S_DRAIN: begin
        cnt_s = cnt_r + CNT_ONE;
        if (div_resp_valid || (cnt_r == CNT_LAST)) begin
          state_s = S_IDLE;
        end else begin
          state_s = S_DRAIN;
        end
      end
      S_DONE: begin
        if (op_kill || res_ready) begin
          state_s    = S_IDLE;
          res_data_s = 32'h0000_0000;
          res_err_s  = 1'b0;
        end else begin
          state_s = S_DONE;
        end
      end
      default: begin
        state_s    = S_IDLE;
        cnt_s      = CNT_ZERO;
        res_data_s = 32'h0000_0000;
        res_err_s  = 1'b0;
      end
    endcase
  end

  // State, counter and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= S_IDLE;
      cnt_r      <= CNT_ZERO;
      res_data_r <= 32'h0000_0000;
      res_err_r  <= 1'b0;
    end else begin
      state_r    <= state_s;
      cnt_r      <= cnt_s;
      res_data_r <= res_data_s;
      res_err_r  <= res_err_s;
    end
  end

  // Operand latches, loaded only on accept so the divider request stays stable.
  always_ff @(posedge clk) begin
    if (rst) begin
      sel_r <= 2'd0;
      a_r   <= 32'h0000_0000;
      b_r   <= 32'h0000_0000;
    end else if (accept_s) begin
      sel_r <= op_sel;
      a_r   <= op_a;
      b_r   <= op_b;
    end else begin
      sel_r <= sel_r;
      a_r   <= a_r;
      b_r   <= b_r;
    end
  end

  assign op_ready       = (state_r == S_IDLE);
  assign busy           = (state_r != S_IDLE);
  assign res_valid      = (state_r == S_DONE);
  assign res_data       = res_data_r;
  assign res_err        = res_err_r;
  assign div_req_valid  = (state_r == S_ISSUE);
  assign div_req_signed = ~sel_r[0];
  assign div_req_rem    = sel_r[1];
  assign div_req_a      = a_r;
  assign div_req_b      = b_r;

endmodule
